mips_multicycle_ctrl: RTL and testbench

Multicycle control unit for the MIPS core: a Moore state machine that sequences a shared-memory, shared-ALU datapath through fetch, decode, execute, memory and writeback steps. It sits beside the datapath in place of the single-cycle combinational controller. It drives every datapath select and enable each cycle. It stalls on a memory-ready handshake so that one unified instruction/data memory can serve both fetches and loads/stores.

---
 rtl/mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences the shared memory/ALU datapath.
// A memory-ready handshake stalls FETCH, MEMRD and MEMWR so that one unified memory can serve every access.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  // state  | meaning
  // FETCH  | read instr at PC, PC+4 -> PC when memory is ready
  // DECODE | read registers, branch target -> ALUOut
  // MEMADR | effective address for lw/sw
  // MEMRD  | load data read
  // MEMWB  | load data -> rt
  // MEMWR  | store data write
  // EXEC   | R-type ALU operation
  // ALUWB  | ALUOut -> rd
  // BRANCH | beq compare and conditional PC update
  // ADDIEX | rs + immediate
  // ADDIWB | ALUOut -> rt
  // JUMP   | jump target -> PC
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alucontrol = 3'b010;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        state_d   = ALUWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   illegal    = 1'b1;
        endcase
      end
      // An illegal funct still writes back, as the single-cycle core does.
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alucontrol = 3'b110;
        pc_src     = 2'b01;
        pc_write   = zero;
        retire     = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, stalls and reset.
// Every expected value below is worked out by hand from the state sequence.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, retire, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alucontrol;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alucontrol(alucontrol),
    .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rt_cnt, rw_cnt, mw_cnt, il_cnt, mtr_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    n_cmp++;
    assert ({24'd0, obs} === exp[31:0]) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are always changed here, 2 time units after the edge, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    rt_cnt = 0; rw_cnt = 0; mw_cnt = 0; il_cnt = 0; mtr_cnt = 0;
  endtask

  task automatic sample();
    rt_cnt  += int'(retire);
    rw_cnt  += int'(reg_write);
    mw_cnt  += int'(mem_write);
    il_cnt  += int'(illegal);
    mtr_cnt += int'(mem_to_reg);
  endtask

  task automatic walk(input string tag, input int seq[8], input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s_state%0d", tag, i), 8'(state), seq[i]);
      sample();
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
    #3;
    chk("rst_state", 8'(state), 0);
    chk("rst_mem_req", 8'(mem_req), 1);
    chk("rst_alu_src_b", 8'(alu_src_b), 1);
    chk("rst_alucontrol", 8'(alucontrol), 2);
    chk("rst_ir_write_rdy", 8'(ir_write), 1);
    chk("rst_reg_write", 8'(reg_write), 0);
    chk("rst_mem_write", 8'(mem_write), 0);
    mem_ready = 1'b0;
    #1;
    chk("rst_ir_write_nrdy", 8'(ir_write), 0);
    chk("rst_pc_write_nrdy", 8'(pc_write), 0);
    mem_ready = 1'b1;
    #4;
    rst = 1'b0;
    #1;
    chk("rel_state", 8'(state), 0);

    // lw: 0,1,2,3,4 then back to 0
    clr_cnt();
    walk("lw", '{1, 2, 3, 4, 0, 0, 0, 0}, 5);
    chk("lw_retire_cnt", 8'(rt_cnt), 1);
    chk("lw_reg_write_cnt", 8'(rw_cnt), 1);
    chk("lw_mem_to_reg_cnt", 8'(mtr_cnt), 1);
    chk("lw_mem_write_cnt", 8'(mw_cnt), 0);

    // sw with 3 stalled cycles in MEMWR: 7 cycles total
    opcode = 6'b101011;
    clr_cnt();
    walk("sw", '{1, 2, 5, 0, 0, 0, 0, 0}, 3);
    chk("sw_iord", 8'(iord), 1);
    mem_ready = 1'b0;
    #1;
    chk("sw_retire_stall", 8'(retire), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sw_stall_state%0d", i), 8'(state), 5);
      chk($sformatf("sw_stall_mem_write%0d", i), 8'(mem_write), 1);
      sample();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_retire_done", 8'(retire), 1);
    tick();
    chk("sw_back_fetch", 8'(state), 0);
    chk("sw_mem_write_cnt", 8'(mw_cnt), 4);
    chk("sw_reg_write_cnt", 8'(rw_cnt), 0);

    // R-type slt
    opcode = 6'b000000; funct = 6'b101010;
    tick(); chk("slt_decode", 8'(state), 1);
    tick(); chk("slt_exec", 8'(state), 6);
    chk("slt_alucontrol", 8'(alucontrol), 7);
    chk("slt_alu_src_a", 8'(alu_src_a), 1);
    chk("slt_alu_src_b", 8'(alu_src_b), 0);
    chk("slt_illegal", 8'(illegal), 0);
    tick(); chk("slt_aluwb", 8'(state), 7);
    chk("slt_reg_dst", 8'(reg_dst), 1);
    chk("slt_reg_write", 8'(reg_write), 1);
    chk("slt_retire", 8'(retire), 1);
    tick(); chk("slt_fetch", 8'(state), 0);

    // R-type with unsupported funct: illegal in EXEC, add, still writes back
    funct = 6'b000000;
    tick(); tick();
    chk("badf_exec", 8'(state), 6);
    chk("badf_illegal", 8'(illegal), 1);
    chk("badf_alucontrol", 8'(alucontrol), 2);
    tick(); chk("badf_reg_write", 8'(reg_write), 1);
    tick(); chk("badf_fetch", 8'(state), 0);

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    tick(); chk("beq1_decode", 8'(state), 1);
    chk("beq1_decode_pc_write", 8'(pc_write), 0);
    tick(); chk("beq1_branch", 8'(state), 8);
    chk("beq1_pc_write", 8'(pc_write), 1);
    chk("beq1_pc_src", 8'(pc_src), 1);
    chk("beq1_alucontrol", 8'(alucontrol), 6);
    chk("beq1_retire", 8'(retire), 1);
    tick(); chk("beq1_fetch", 8'(state), 0);
    zero = 1'b0;
    tick(); tick();
    chk("beq0_branch", 8'(state), 8);
    chk("beq0_pc_write", 8'(pc_write), 0);
    chk("beq0_retire", 8'(retire), 1);
    tick(); chk("beq0_fetch", 8'(state), 0);

    // addi and j
    opcode = 6'b001000;
    clr_cnt();
    walk("addi", '{1, 9, 10, 0, 0, 0, 0, 0}, 2);
    chk("addi_alu_src_b", 8'(alu_src_b), 2);
    tick(); chk("addiwb_state", 8'(state), 10);
    chk("addi_reg_dst", 8'(reg_dst), 0);
    chk("addi_reg_write", 8'(reg_write), 1);
    tick(); chk("addi_fetch", 8'(state), 0);
    opcode = 6'b000010;
    tick(); tick();
    chk("j_state", 8'(state), 11);
    chk("j_pc_src", 8'(pc_src), 2);
    chk("j_pc_write", 8'(pc_write), 1);
    tick(); chk("j_fetch", 8'(state), 0);

    // illegal opcode: 2 cycles
    opcode = 6'b111111;
    clr_cnt();
    tick(); chk("ill_decode", 8'(state), 1);
    chk("ill_illegal", 8'(illegal), 1);
    chk("ill_retire", 8'(retire), 1);
    sample();
    tick(); chk("ill_fetch", 8'(state), 0);
    chk("ill_reg_write_cnt", 8'(rw_cnt), 0);
    chk("ill_mem_write_cnt", 8'(mw_cnt), 0);

    // FETCH stall, then reset during MEMRD
    opcode = 6'b100011; mem_ready = 1'b0;
    #1;
    chk("fst_ir_write0", 8'(ir_write), 0);
    tick(); chk("fst_state1", 8'(state), 0);
    chk("fst_ir_write1", 8'(ir_write), 0);
    tick(); chk("fst_state2", 8'(state), 0);
    chk("fst_pc_write2", 8'(pc_write), 0);
    mem_ready = 1'b1;
    tick(); chk("fst_decode", 8'(state), 1);
    tick(); chk("fst_memadr", 8'(state), 2);
    mem_ready = 1'b0;
    tick(); chk("fst_memrd", 8'(state), 3);
    tick(); chk("fst_memrd_hold", 8'(state), 3);
    rst = 1'b1;
    #1;
    chk("mrst_state", 8'(state), 0);
    chk("mrst_reg_write", 8'(reg_write), 0);
    chk("mrst_mem_write", 8'(mem_write), 0);
    tick(); chk("mrst_state_edge", 8'(state), 0);
    chk("mrst_reg_write_edge", 8'(reg_write), 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
